as_gpio_out: RTL
================

# as_gpio_out

Memory-mapped GPIO output port. Accepts store requests from the core's data-bus side and replays them, in order and paced, as single-cycle `cs_o` strobes on the `gpio_o` / `gpioAddr_o` / `cs_o` interface that the integration benches monitor. It sits between the data-memory decoder and the top-level GPIO pins of `as_top_mem`. A small FIFO decouples core store bursts from the output strobe rate.

## Interface
- `nr_gpios`, 64: width of the data bus and of `gpio_o`.
- `gpio_addr_width`, 4: GPIO address width.
- `fifo_depth`, 4: write FIFO entries; power of two, ≥2.
- `strobe_gap`, 1: minimum number of idle cycles with `cs_o`=0 between two strobes; 0 allows back-to-back strobes.

Ports:
- `clk_i`  in  1  clock; rising-edge active.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `req_i`  in  1  bus request valid.
- `we_i`  in  1  1 = write, 0 = read.
- `addr_i`  in  gpio_addr_width  target GPIO address.
- `wdata_i`  in  nr_gpios  write data.
- `ack_o`  out  1  request accepted, registered.
- `rdata_o`  out  nr_gpios  read data, valid while `ack_o`=1.
- `gpio_o`  out  nr_gpios  output data, held between strobes.
- `gpioAddr_o`  out  gpio_addr_width  output address, held between strobes.
- `cs_o`  out  1  one-cycle strobe qualifying `gpio_o` / `gpioAddr_o`.

## Operation
- **Write acceptance:** a write is accepted when, at a rising edge, `req_i`=1, `we_i`=1 and the FIFO is not full.
  - The `{addr_i, wdata_i}` pair is pushed.
  - `ack_o`=1 for the following cycle.
- **Write stall:** when the FIFO is full, no push and no ack. The master holds `req_i`, `addr_i` and `wdata_i` stable until ack. A full FIFO blocks a push even if a pop occurs at the same edge.
- **Read acceptance:** a read (`req_i`=1, `we_i`=0) is always accepted. `ack_o`=1 next cycle, with `rdata_o` per Configuration.
- **Output FSM:**
  - IDLE: FIFO empty → stay. Not empty → pop; load `gpio_o` / `gpioAddr_o`; set `cs_o`=1; go to STROBE.
  - STROBE: `cs_o`=0 at next edge.
    - `strobe_gap`=0 and FIFO not empty → pop immediately and stay in STROBE with `cs_o`=1.
    - `strobe_gap`=0 and FIFO empty → IDLE.
    - `strobe_gap`>0 → GAP, with the gap counter loaded to `strobe_gap`-1.
  - GAP: decrement the counter each cycle. At 0, behave as IDLE in that same cycle: pop → STROBE, else → IDLE.
- **Ordering:** strictly FIFO. FIFO pointers wrap modulo `fifo_depth`. The count is `clog2(fifo_depth)+1` bits wide.
- **Output hold:** `gpio_o` and `gpioAddr_o` change only on a pop edge.
- **Non-write bus cycles:** `rdata_o`=0 whenever `ack_o`=0.

## Timing
- **Reset values:**
  - `ack_o`=0, `rdata_o`=0, `gpio_o`=0, `gpioAddr_o`=0, `cs_o`=0.
  - FIFO empty; FSM in IDLE; gap counter 0.
  - Shadow registers (if compiled in) = 0.
- **Latency:** write request sampled at edge N; `ack_o` is high in cycle N..N+1. With the FIFO previously empty, the pop happens at edge N+1, so `cs_o`, `gpio_o` and `gpioAddr_o` are valid in cycle N+1..N+2.
- **Strobe spacing:** under a sustained backlog, strobes occur every `strobe_gap`+1 cycles.
- **Back-to-back requests:** a master holding `req_i` across cycles gets one accepted transfer per cycle while the FIFO is not full.
- **Reset mid-operation:** asserting `rst_i` discards all FIFO contents and any strobe in progress. Outputs return to reset values asynchronously. No stale strobe is produced after reset release.

## Configuration
- **`AS_GPIO_READBACK_EN` defined:**
  - Includes a `2^gpio_addr_width` × `nr_gpios` shadow register file.
  - Every accepted write updates the shadow at `addr_i` at acceptance time, not at strobe time.
  - A read returns the shadow at `addr_i`.
- **`AS_GPIO_READBACK_EN` undefined:**
  - No shadow storage.
  - A read returns status, zero-extended: bit0 = FIFO empty, bit1 = FIFO full, bits [2+:clog2(fifo_depth)+1] = FIFO count.

## Test plan
- **Single write:** reset for 10 cycles, then write addr 4, data 42 → `ack_o` 1 cycle later, `cs_o` high exactly 1 cycle, 2 cycles after request, with `gpioAddr_o`=4 and `gpio_o`=42. Both values are held afterwards.
- **Burst, `fifo_depth`=4, `strobe_gap`=2:** hold `req_i` for 8 writes, data 1..8 → `ack_o` deasserts while full. All 8 strobes appear in order 1..8, spaced exactly 3 cycles apart, with no loss or duplication.
- **Back-to-back, `strobe_gap`=0:** 3 consecutive writes → 3 consecutive `cs_o` cycles, data in order.
- **Reset mid-operation:** queue 4 writes and assert `rst_i` after the first strobe → all outputs 0 immediately. No `cs_o` after release until a new write; a new write of 7 strobes 7.
- **Readback (`AS_GPIO_READBACK_EN` defined):** write 0x55 to addr 2, then read addr 2 → `rdata_o`=0x55, even before the strobe has occurred.
- **Status (`AS_GPIO_READBACK_EN` undefined):** fill the FIFO while stalled, then read → bit1=1 and count=`fifo_depth`. Read again after the FIFO drains → bit0=1 and count=0.

Source files
------------

// File: rtl/as_gpio_out_if.sv
`default_nettype none
// ============================================================================
// Module   : as_gpio_out_if
// Purpose  : Store-request bus and paced GPIO strobe outputs of as_gpio_out.
// Revision : 1.0 - initial release
// ============================================================================
interface as_gpio_out_if #(
  parameter int NR_GPIOS        = 64,
  parameter int GPIO_ADDR_WIDTH = 4
);
  logic                       req_i;
  logic                       we_i;
  logic [GPIO_ADDR_WIDTH-1:0] addr_i;
  logic [NR_GPIOS-1:0]        wdata_i;
  logic                       ack_o;
  logic [NR_GPIOS-1:0]        rdata_o;
  logic [NR_GPIOS-1:0]        gpio_o;
  logic [GPIO_ADDR_WIDTH-1:0] gpioAddr_o;
  logic                       cs_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i,
    input  ack_o, rdata_o, gpio_o, gpioAddr_o, cs_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i,
    output ack_o, rdata_o, gpio_o, gpioAddr_o, cs_o
  );
endinterface
`default_nettype wire

// File: rtl/as_gpio_out.sv
`default_nettype none
// ============================================================================
// Module   : as_gpio_out
// Purpose  : FIFO-buffered GPIO output port replaying stores as paced strobes.
//            Optional shadow readback via `AS_GPIO_READBACK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module as_gpio_out #(
  parameter int NR_GPIOS        = 64,
  parameter int GPIO_ADDR_WIDTH = 4,
  parameter int FIFO_DEPTH      = 4,
  parameter int STROBE_GAP      = 1
) (
  input  wire logic       clk_i,
  input  wire logic       rst_i,
  as_gpio_out_if.slave    bus
);
  localparam int c_ptr_w = $clog2(FIFO_DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam int c_ent_w = GPIO_ADDR_WIDTH + NR_GPIOS;
  localparam int c_gap_w = (STROBE_GAP > 1) ? $clog2(STROBE_GAP) : 1;
  localparam logic [c_gap_w-1:0] c_gap_load =
    (STROBE_GAP > 0) ? c_gap_w'(STROBE_GAP - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STROBE = 2'd1,
    S_GAP    = 2'd2
  } state_t;

  logic [c_ent_w-1:0]         r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0]         r_wr_ptr, r_rd_ptr;
  logic [c_cnt_w-1:0]         r_count;
  state_t                     r_state, w_state_nxt;
  logic [c_gap_w-1:0]         r_gap, w_gap_nxt;
  logic                       w_pop, w_cs_nxt;
  logic                       r_ack, r_cs;
  logic [NR_GPIOS-1:0]        r_rdata, r_gpio, w_rd_val;
  logic [GPIO_ADDR_WIDTH-1:0] r_gpio_addr;

  wire logic w_empty = (r_count == '0);
  wire logic w_full  = (r_count == c_cnt_w'(FIFO_DEPTH));
  // Full is judged on the pre-edge count, so a same-edge pop never frees a slot.
  wire logic w_push  = bus.req_i & bus.we_i & ~w_full;
  wire logic w_rd    = bus.req_i & ~bus.we_i;

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= {bus.addr_i, bus.wdata_i};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef AS_GPIO_READBACK_EN
  logic [NR_GPIOS-1:0] r_shadow [2**GPIO_ADDR_WIDTH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 2**GPIO_ADDR_WIDTH; i++) r_shadow[i] <= '0;
    end else if (w_push) begin
      r_shadow[bus.addr_i] <= bus.wdata_i;
    end
  end

  assign w_rd_val = r_shadow[bus.addr_i];
`else
  assign w_rd_val = NR_GPIOS'({r_count, w_full, w_empty});
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack   <= w_push | w_rd;
      r_rdata <= w_rd ? w_rd_val : '0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gap_nxt   = r_gap;
    w_pop       = 1'b0;
    w_cs_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_cs_nxt    = 1'b1;
          w_state_nxt = S_STROBE;
        end
      end
      S_STROBE: begin
        if (STROBE_GAP == 0) begin
          if (!w_empty) begin
            w_pop    = 1'b1;
            w_cs_nxt = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_gap_nxt   = c_gap_load;
          w_state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        // The last gap cycle doubles as an idle cycle to keep spacing at gap+1.
        if (r_gap == '0) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_cs_nxt    = 1'b1;
            w_state_nxt = S_STROBE;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_gap_nxt = r_gap - c_gap_w'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_gap       <= '0;
      r_cs        <= 1'b0;
      r_gpio      <= '0;
      r_gpio_addr <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gap   <= w_gap_nxt;
      r_cs    <= w_cs_nxt;
      if (w_pop) {r_gpio_addr, r_gpio} <= r_mem[r_rd_ptr];
    end
  end

  assign bus.ack_o      = r_ack;
  assign bus.rdata_o    = r_rdata;
  assign bus.gpio_o     = r_gpio;
  assign bus.gpioAddr_o = r_gpio_addr;
  assign bus.cs_o       = r_cs;
endmodule
`default_nettype wire
